sum_feeder: RTL

SUM_FEEDER -- requirements
Module: sum_feeder

---
 rtl/sum_feeder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sum_feeder.sv
// Queues up to eight non-zero operands and streams them to a downstream summer:
// a one-cycle active-low go strobe, the operands back to back, then a zero terminator.
module sum_feeder (
    input  logic        ck,
    input  logic        reset_l,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    output logic        wr_ready,
    input  logic        start,
    output logic        busy,
    output logic        go_l,
    output logic [15:0] inA,
    input  logic        done,
    output logic        err,
    output logic [3:0]  count,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GO     = 3'd1,
        S_STREAM = 3'd2,
        S_TERM   = 3'd3,
        S_WAIT   = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] mem [8];
    logic [2:0]  rd_ptr;
    logic [2:0]  wr_ptr;
    logic [2:0]  wd;

    logic wr_acc;
    logic wr_drop;
    logic pop;
    logic start_ok;
    logic start_bad;
    logic wd_timeout;

    // Handshake: a write is taken on any ck edge where wr_en && wr_ready && wr_data != 0;
    // wr_ready only reflects IDLE and space, so a zero operand is refused and flagged.
    assign wr_acc  = wr_en && (state == S_IDLE) && (count != 4'd8) && (wr_data != 16'd0);
    assign wr_drop = wr_en && !wr_acc;

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        start_ok   = 1'b0;
        start_bad  = 1'b0;
        wd_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (count != 4'd0) begin
                        start_ok  = 1'b1;
                        state_nxt = S_GO;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            S_GO:     state_nxt = S_STREAM;
            S_STREAM: begin
                pop = 1'b1;
                if (count == 4'd1) state_nxt = S_TERM;
            end
            S_TERM:   state_nxt = S_WAIT;
            S_WAIT: begin
                if (done) begin
                    state_nxt = S_IDLE;
                end else if (wd == 3'd3) begin
                    // fourth WAIT cycle without done
                    wd_timeout = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ck or negedge reset_l) begin
        if (!reset_l) begin
            state  <= S_IDLE;
            rd_ptr <= 3'd0;
            wr_ptr <= 3'd0;
            count  <= 4'd0;
            err    <= 1'b0;
            wd     <= 3'd0;
        end else begin
            state <= state_nxt;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 3'd1;
                count  <= count + 4'd1;
            end else if (pop) begin
                rd_ptr <= rd_ptr + 3'd1;
                count  <= count - 4'd1;
            end
            if (wr_drop || start_bad || wd_timeout) begin
                err <= 1'b1;
            end else if (start_ok) begin
                err <= 1'b0;
            end
            if (state == S_TERM) begin
                wd <= 3'd0;
            end else if ((state == S_WAIT) && !done) begin
                wd <= wd + 3'd1;
            end
        end
    end

    // Storage is validated by the pointers and count alone, so it carries no reset.
    always_ff @(posedge ck) begin
        if (wr_acc) mem[wr_ptr] <= wr_data;
    end

    assign wr_ready  = (state == S_IDLE) && (count != 4'd8);
    assign busy      = (state != S_IDLE);
    assign go_l      = (state != S_GO);
    assign inA       = (state == S_STREAM) ? mem[rd_ptr] : 16'd0;
    assign state_dbg = state;

endmodule
